// File: rtl/key_pkg.sv
// Shared types for the key step scheduler: FSM states, owner encoding and a
// small helper for sizing the interval timer.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_e;

    localparam logic OWN_PLUS  = 1'b1;
    localparam logic OWN_MINUS = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_step_scheduler_if.sv
// Valid/ready step channel from the scheduler to the up/down counter datapath.
interface key_step_scheduler_if;

    logic step_vld;
    logic step_up;
    logic step_rdy;

    modport master (
        output step_vld,
        output step_up,
        input  step_rdy
    );

    modport slave (
        input  step_vld,
        input  step_up,
        output step_rdy
    );

endinterface

// File: rtl/key_interval_timer.sv
// Loadable down-counter that pulses expire on the edge where it steps from 1 to 0.
module key_interval_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clear,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over clear so an expiry that reloads keeps counting.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (clear) begin
            count_d = '0;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == W'(1));

endmodule

// File: rtl/key_step_scheduler.sv
// Turns the plus/minus key levels into arbitrated, auto-repeating step
// commands delivered over a valid/ready channel.
module key_step_scheduler
    import key_pkg::*;
#(
    parameter int HOLD_CYC   = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000
) (
    input  logic                         clk_50mhz,
    input  logic                         rst_n,
    input  logic                         key_plus_n,
    input  logic                         key_minus_n,
    key_step_scheduler_if.master         step_if,
    output logic                         busy,
    output logic                         overrun
);

    localparam int TW = $clog2(max_int(HOLD_CYC, REPEAT_CYC) + 1);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          plus_q, minus_q;
    logic          step_vld_q, step_vld_d;
    logic          step_up_q, step_up_d;
    logic          overrun_q, overrun_d;
    logic          tmr_load, tmr_clear, tmr_expire;
    logic [TW-1:0] tmr_load_val;
    logic          issue;
    logic          plus_press, minus_press, transfer;
    logic          owner_released, other_held;

    assign plus_press     = plus_q & ~key_plus_n;
    assign minus_press    = minus_q & ~key_minus_n;
    assign transfer       = step_vld_q & step_if.step_rdy;
    assign owner_released = (owner_q == OWN_PLUS) ? key_plus_n : key_minus_n;
    assign other_held     = (owner_q == OWN_PLUS) ? ~key_minus_n : ~key_plus_n;

    key_interval_timer #(.W(TW)) u_timer (
        .clk      (clk_50mhz),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .clear    (tmr_clear),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        step_vld_d   = step_vld_q;
        step_up_d    = step_up_q;
        overrun_d    = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_clear    = 1'b0;
        issue        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (plus_press && key_minus_n) begin
                    owner_d      = OWN_PLUS;
                    issue        = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(HOLD_CYC);
                    state_d      = HOLD;
                end else if (minus_press && key_plus_n) begin
                    owner_d      = OWN_MINUS;
                    issue        = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(HOLD_CYC);
                    state_d      = HOLD;
                end else if (plus_press || minus_press) begin
                    state_d = LOCK;
                end
            end
            HOLD, REPEAT: begin
                if (owner_released) begin
                    tmr_clear = 1'b1;
                    state_d   = IDLE;
                end else if (other_held) begin
                    tmr_clear = 1'b1;
                    state_d   = LOCK;
                end else if (tmr_expire) begin
                    issue        = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(REPEAT_CYC);
                    state_d      = REPEAT;
                end
            end
            LOCK: begin
                if (key_plus_n && key_minus_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A step that cannot be posted is dropped rather than queued.
        if (issue) begin
            if (!step_vld_q || transfer) begin
                step_vld_d = 1'b1;
                step_up_d  = (owner_d == OWN_PLUS);
            end else begin
                overrun_d = 1'b1;
            end
        end else if (transfer) begin
            step_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_MINUS;
            plus_q     <= 1'b0;
            minus_q    <= 1'b0;
            step_vld_q <= 1'b0;
            step_up_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            plus_q     <= key_plus_n;
            minus_q    <= key_minus_n;
            step_vld_q <= step_vld_d;
            step_up_q  <= step_up_d;
            overrun_q  <= overrun_d;
        end
    end

    assign step_if.step_vld = step_vld_q;
    assign step_if.step_up  = step_up_q;
    assign busy             = (state_q == HOLD) || (state_q == REPEAT);
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_key_step_scheduler.sv
// Self-checking bench: directed scenarios plus random key/ready traffic, all
// compared cycle by cycle against an absolute-deadline reference model.
module tb_key_step_scheduler;

    localparam int HOLD   = 8;
    localparam int REPEAT = 4;

    logic clk_50mhz;
    logic rst_n;
    logic key_plus_n;
    logic key_minus_n;
    logic busy;
    logic overrun;

    key_step_scheduler_if step_bus ();

    key_step_scheduler #(
        .HOLD_CYC   (HOLD),
        .REPEAT_CYC (REPEAT)
    ) dut (
        .clk_50mhz   (clk_50mhz),
        .rst_n       (rst_n),
        .key_plus_n  (key_plus_n),
        .key_minus_n (key_minus_n),
        .step_if     (step_bus.master),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk_50mhz = 1'b0;
    always #5 clk_50mhz = ~clk_50mhz;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = idle, 1 = a key owns the scheduler, 2 = locked.
    int     m_mode;
    bit     m_own_plus;
    longint m_cyc;
    longint m_due;
    bit     m_plus_prev, m_minus_prev;
    bit     m_vld, m_up, m_ovr;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode       = 0;
        m_own_plus   = 1'b0;
        m_due        = 0;
        m_plus_prev  = 1'b0;
        m_minus_prev = 1'b0;
        m_vld        = 1'b0;
        m_up         = 1'b0;
        m_ovr        = 1'b0;
    endtask

    task automatic model_edge(input bit p_n, input bit n_n, input bit rdy);
        bit pp, mp, xfer, fire, own_n, oth_n;
        pp   = m_plus_prev & !p_n;
        mp   = m_minus_prev & !n_n;
        xfer = m_vld & rdy;
        fire = 1'b0;
        case (m_mode)
            0: begin
                if (pp && n_n) begin
                    m_own_plus = 1'b1; fire = 1'b1; m_due = m_cyc + HOLD; m_mode = 1;
                end else if (mp && p_n) begin
                    m_own_plus = 1'b0; fire = 1'b1; m_due = m_cyc + HOLD; m_mode = 1;
                end else if (pp || mp) begin
                    m_mode = 2;
                end
            end
            1: begin
                own_n = m_own_plus ? p_n : n_n;
                oth_n = m_own_plus ? n_n : p_n;
                if (own_n) m_mode = 0;
                else if (!oth_n) m_mode = 2;
                else if (m_cyc == m_due) begin
                    fire = 1'b1; m_due = m_cyc + REPEAT;
                end
            end
            default: if (p_n && n_n) m_mode = 0;
        endcase
        m_ovr = 1'b0;
        if (fire) begin
            if (!m_vld || xfer) begin
                m_vld = 1'b1;
                m_up  = m_own_plus;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (xfer) begin
            m_vld = 1'b0;
        end
        m_plus_prev  = p_n;
        m_minus_prev = n_n;
        m_cyc++;
    endtask

    task automatic compare_all();
        checkOutput("step_vld", step_bus.step_vld, m_vld);
        if (m_vld) checkOutput("step_up", step_bus.step_up, m_up);
        checkOutput("busy", busy, (m_mode == 1));
        checkOutput("overrun", overrun, m_ovr);
    endtask

    task automatic run_cycle();
        bit p_n, n_n, rdy;
        @(posedge clk_50mhz);
        p_n = key_plus_n;
        n_n = key_minus_n;
        rdy = step_bus.step_rdy;
        if (rst_n) model_edge(p_n, n_n, rdy);
        @(negedge clk_50mhz);
        compare_all();
    endtask

    task automatic applyStimulus(input bit p_n, input bit n_n, input bit rdy, input int cycles);
        key_plus_n        = p_n;
        key_minus_n       = n_n;
        step_bus.step_rdy = rdy;
        for (int i = 0; i < cycles; i++) run_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        m_cyc             = 0;
        model_reset();
        rst_n             = 1'b0;
        key_plus_n        = 1'b1;
        key_minus_n       = 1'b1;
        step_bus.step_rdy = 1'b0;

        applyStimulus(1, 1, 0, 3);
        rst_n = 1'b1;

        // Single tap, then hold of minus with free-flowing ready.
        applyStimulus(1, 1, 1, 3);
        applyStimulus(0, 1, 1, 3);
        applyStimulus(1, 1, 1, 5);
        applyStimulus(1, 0, 1, 20);
        applyStimulus(1, 1, 1, 6);

        // Backpressure across the first repeat, then release ready.
        applyStimulus(0, 1, 0, 11);
        applyStimulus(0, 1, 1, 7);
        applyStimulus(1, 1, 1, 4);

        // Conflicts: simultaneous press, then minus joining a held plus.
        applyStimulus(0, 0, 1, 3);
        applyStimulus(1, 1, 1, 2);
        applyStimulus(0, 1, 1, 3);
        applyStimulus(1, 1, 1, 3);
        applyStimulus(0, 1, 1, 5);
        applyStimulus(0, 0, 1, 6);
        applyStimulus(1, 1, 1, 2);
        applyStimulus(0, 1, 1, 2);
        applyStimulus(1, 1, 1, 3);

        // Plus held through reset release must stay silent until re-pressed.
        key_plus_n = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        applyStimulus(0, 1, 1, 3);
        rst_n = 1'b1;
        applyStimulus(0, 1, 1, 5);
        applyStimulus(1, 1, 1, 2);
        applyStimulus(0, 1, 1, 2);
        applyStimulus(1, 1, 1, 3);

        // Asynchronous reset while a step is pending.
        applyStimulus(0, 1, 0, 2);
        checkOutput("vld_pending", step_bus.step_vld, 1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("async_vld", step_bus.step_vld, 0);
        checkOutput("async_busy", busy, 0);
        applyStimulus(1, 1, 0, 2);
        rst_n = 1'b1;
        applyStimulus(1, 1, 1, 2);

        // Random traffic: slowly toggling keys, mostly-ready counter.
        for (int i = 0; i < 3000; i++) begin
            bit p_n, n_n, rdy;
            p_n = key_plus_n;
            n_n = key_minus_n;
            if ($urandom_range(0, 15) == 0) p_n = ~p_n;
            if ($urandom_range(0, 23) == 0) n_n = ~n_n;
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(p_n, n_n, rdy, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
